// File: rtl/mc_datapath_if.sv
// Instruction handshake between the instruction source (master) and mc_datapath (slave).
interface mc_datapath_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath (IDLE/DECODE/EXEC/MEM/WB) with register file and data memory.
// Define MC_DATAPATH_BRANCH_EN to add beq/bne and the branch_taken output.
module mc_datapath #(
    parameter int XLEN       = 32,
    parameter int DMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            rst,
    mc_datapath_if.slave    ibus,
    output logic            done,
    output logic            illegal,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            iszero
`ifdef MC_DATAPATH_BRANCH_EN
    ,
    output logic            branch_taken
`endif
);
    localparam int AW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    state_e          state_r, state_s;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] a_r, b_r, alu_out_r, mdr_r;
    logic            iszero_r;
    logic [XLEN-1:0] regs_r [32];
    logic [XLEN-1:0] dmem_r [DMEM_WORDS];

    logic [5:0]      op_s, funct_s;
    logic [4:0]      rs_s, rt_s, rd_s;
    logic [XLEN-1:0] imm_s, rs_data_s, rt_data_s, opnd_b_s, alu_res_s;
    logic [AW-1:0]   dmem_addr_s;
    alu_op_e         alu_op_s;
    logic            legal_s, use_imm_s, is_lw_s, is_sw_s, is_br_s, dest_rd_s;
    logic            done_s, illegal_s, wb_en_s;
    logic [4:0]      wb_addr_s;
    logic [XLEN-1:0] wb_data_s;

    assign op_s        = ir_r[31:26];
    assign rs_s        = ir_r[25:21];
    assign rt_s        = ir_r[20:16];
    assign rd_s        = ir_r[15:11];
    assign funct_s     = ir_r[5:0];
    assign imm_s       = {{(XLEN-16){ir_r[15]}}, ir_r[15:0]};
    assign rs_data_s   = (rs_s == 5'd0) ? {XLEN{1'b0}} : regs_r[rs_s];
    assign rt_data_s   = (rt_s == 5'd0) ? {XLEN{1'b0}} : regs_r[rt_s];
    assign dmem_addr_s = alu_out_r[AW+1:2];

    // Instruction decode from the latched IR.
    always_comb begin
        legal_s   = 1'b0;
        alu_op_s  = ALU_ADD;
        use_imm_s = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        is_br_s   = 1'b0;
        dest_rd_s = 1'b0;
        case (op_s)
            6'h00: begin
                dest_rd_s = 1'b1;
                case (funct_s)
                    6'h20:   begin legal_s = 1'b1; alu_op_s = ALU_ADD; end
                    6'h22:   begin legal_s = 1'b1; alu_op_s = ALU_SUB; end
                    6'h24:   begin legal_s = 1'b1; alu_op_s = ALU_AND; end
                    6'h25:   begin legal_s = 1'b1; alu_op_s = ALU_OR;  end
                    6'h27:   begin legal_s = 1'b1; alu_op_s = ALU_NOR; end
                    6'h2A:   begin legal_s = 1'b1; alu_op_s = ALU_SLT; end
                    default: legal_s = 1'b0;
                endcase
            end
            6'h08:   begin legal_s = 1'b1; use_imm_s = 1'b1; end
            6'h23:   begin legal_s = 1'b1; use_imm_s = 1'b1; is_lw_s = 1'b1; end
            6'h2B:   begin legal_s = 1'b1; use_imm_s = 1'b1; is_sw_s = 1'b1; end
`ifdef MC_DATAPATH_BRANCH_EN
            6'h04, 6'h05: begin legal_s = 1'b1; alu_op_s = ALU_SUB; is_br_s = 1'b1; end
`endif
            default: legal_s = 1'b0;
        endcase
    end

    // ALU: A op (B or sign-extended immediate); add/sub wrap.
    always_comb begin
        opnd_b_s = use_imm_s ? imm_s : b_r;
        case (alu_op_s)
            ALU_ADD: alu_res_s = a_r + opnd_b_s;
            ALU_SUB: alu_res_s = a_r - opnd_b_s;
            ALU_AND: alu_res_s = a_r & opnd_b_s;
            ALU_OR:  alu_res_s = a_r | opnd_b_s;
            ALU_NOR: alu_res_s = ~(a_r | opnd_b_s);
            ALU_SLT: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(opnd_b_s))};
            default: alu_res_s = a_r + opnd_b_s;
        endcase
    end

    // Control FSM: next state and per-state strobes.
    always_comb begin
        state_s   = state_r;
        done_s    = 1'b0;
        illegal_s = 1'b0;
        wb_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ibus.instr_valid) state_s = ST_DECODE;
                else                  state_s = ST_IDLE;
            end
            ST_DECODE: begin
                if (!legal_s) begin
                    state_s   = ST_IDLE;
                    done_s    = 1'b1;
                    illegal_s = 1'b1;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_br_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (is_lw_s || is_sw_s) begin
                    state_s = ST_MEM;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (is_sw_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_WB: begin
                state_s = ST_IDLE;
                done_s  = 1'b1;
                wb_en_s = 1'b1;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Write-back observation: zero outside WB so idle ports stay quiet.
    always_comb begin
        if (wb_en_s) begin
            wb_addr_s = dest_rd_s ? rd_s : rt_s;
            wb_data_s = is_lw_s ? mdr_r : alu_out_r;
        end else begin
            wb_addr_s = 5'd0;
            wb_data_s = {XLEN{1'b0}};
        end
    end

    assign ibus.instr_ready = (state_r == ST_IDLE);
    assign done    = done_s;
    assign illegal = illegal_s;
    assign wb_en   = wb_en_s;
    assign wb_addr = wb_addr_s;
    assign wb_data = wb_data_s;
    assign iszero  = iszero_r;
`ifdef MC_DATAPATH_BRANCH_EN
    // Opcode bit 0 separates bne (taken on nonzero) from beq (taken on zero).
    assign branch_taken = (state_r == ST_EXEC) && is_br_s && ((alu_res_s == {XLEN{1'b0}}) ^ op_s[0]);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_s;
    end

    // Datapath pipeline registers IR/A/B/ALUOut/MDR and the zero flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_r      <= 32'd0;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            alu_out_r <= {XLEN{1'b0}};
            mdr_r     <= {XLEN{1'b0}};
            iszero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   if (ibus.instr_valid) ir_r <= ibus.instr;
                ST_DECODE: begin
                    a_r <= rs_data_s;
                    b_r <= rt_data_s;
                end
                ST_EXEC: begin
                    alu_out_r <= alu_res_s;
                    iszero_r  <= (alu_res_s == {XLEN{1'b0}});
                end
                ST_MEM:    if (is_lw_s) mdr_r <= dmem_r[dmem_addr_s];
                default:   ;
            endcase
        end
    end

    // Register file write port; writes to r0 are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= {XLEN{1'b0}};
        end else if (wb_en_s && (wb_addr_s != 5'd0)) begin
            regs_r[wb_addr_s] <= wb_data_s;
        end
    end

    // Data memory write port, used by sw in MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) dmem_r[i] <= {XLEN{1'b0}};
        end else if ((state_r == ST_MEM) && is_sw_s) begin
            dmem_r[dmem_addr_s] <= b_r;
        end
    end
endmodule
